// File: rtl/mesh_pkg.sv
// Shared mesh definitions: NIC register map, packet width and packet field positions.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mesh_pkg;

   // Packet and NIC register width.
   localparam int DATA_WIDTH = 64;

   // Virtual-channel tag: a packet may only move on cycles whose polarity matches it.
   localparam int VC_BIT = 63;

   // Packet field positions shared with the router.
   localparam int PKT_VC_BIT      = VC_BIT;
   localparam int PKT_PAYLOAD_MSB = VC_BIT - 1;
   localparam int PKT_PAYLOAD_LSB = 0;

   // NIC register map as seen by the processor.
   localparam logic [1:0] NIC_RX_DATA = 2'b00;
   localparam logic [1:0] NIC_RX_STAT = 2'b01;
   localparam logic [1:0] NIC_TX_DATA = 2'b10;
   localparam logic [1:0] NIC_TX_STAT = 2'b11;

   // Occupancy of a single-entry packet slot.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // Extract the virtual-channel tag of a packet.
   function automatic logic pkt_vc(input logic [DATA_WIDTH-1:0] pkt);
      return pkt[PKT_VC_BIT];
   endfunction

endpackage

// File: rtl/nic_slot.sv
// Single-entry packet buffer with a full flag; loads when empty, empties on drain.
// Latency: data and full flag visible the cycle after the load edge.
// Backpressure: a load while full is dropped; the producer must watch full.
module nic_slot #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         drain,
   input  logic [W-1:0] load_data,
   output logic         full,
   output logic [W-1:0] data
);
   import mesh_pkg::*;

   slot_state_t state;

   // Slot FSM: EMPTY captures on load, FULL releases on drain; the buffer keeps stale data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SLOT_EMPTY;
         data  <= '0;
      end else begin
         case (state)
            SLOT_EMPTY: begin
               if (load) begin
                  data  <= load_data;
                  state <= SLOT_FULL;
               end
            end
            SLOT_FULL: begin
               if (drain) begin
                  state <= SLOT_EMPTY;
               end
            end
            default: state <= SLOT_EMPTY;
         endcase
      end
   end

   assign full = (state == SLOT_FULL);

endmodule

// File: rtl/mesh_nic.sv
// PE-side NIC: processor register port on one side, router PE port on the other.
// Latency: 1 cycle from tx write to earliest send strobe; rx data readable the cycle after arrival.
// Backpressure: tx holds until net_ro and matching polarity; net_ri drops while the rx slot is full.
module mesh_nic #(
   parameter int DATA_WIDTH = 64,
   parameter int VC_BIT     = 63
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            addr,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   output logic                  net_so,
   output logic [DATA_WIDTH-1:0] net_do,
   input  logic                  net_ro,
   input  logic                  net_polarity,
   input  logic                  net_si,
   input  logic [DATA_WIDTH-1:0] net_di,
   output logic                  net_ri
);
   import mesh_pkg::*;

   logic                  tx_full;
   logic                  rx_full;
   logic [DATA_WIDTH-1:0] tx_buf;
   logic [DATA_WIDTH-1:0] rx_buf;
   logic                  rd_en;
   logic                  tx_load;
   logic                  rx_load;
   logic                  rx_drain;

   assign rd_en = nicEn & ~nicWrEn;

   // A tx write while full is dropped inside the slot, so a same-cycle write and send loses the write.
   assign tx_load  = nicEn & nicWrEn & (addr == NIC_TX_DATA);
   assign rx_load  = net_si & net_ri;
   assign rx_drain = rd_en & (addr == NIC_RX_DATA) & rx_full;

   // The packet leaves only on a cycle whose mesh polarity matches its VC tag.
   assign net_so = ~reset & tx_full & net_ro & (net_polarity == tx_buf[VC_BIT]);
   assign net_do = tx_full ? tx_buf : '0;
   assign net_ri = ~rx_full;

   nic_slot #(.W(DATA_WIDTH)) u_tx_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (tx_load),
      .drain     (net_so),
      .load_data (d_in),
      .full      (tx_full),
      .data      (tx_buf)
   );

   nic_slot #(.W(DATA_WIDTH)) u_rx_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (rx_load),
      .drain     (rx_drain),
      .load_data (net_di),
      .full      (rx_full),
      .data      (rx_buf)
   );

   // Processor read mux; returns zero unless a read is enabled.
   always_comb begin
      d_out = '0;
      if (rd_en) begin
         case (addr)
            NIC_RX_DATA: d_out = rx_buf;
            NIC_RX_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, rx_full};
            NIC_TX_DATA: d_out = tx_buf;
            NIC_TX_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, tx_full};
            default:     d_out = '0;
         endcase
      end
   end

endmodule

// File: doc/mesh_nic.md
Name: mesh_nic

Overview:
- PE-side network interface controller for one node of the 4x4 mesh. It is the far end of the router's PE port.
- Accepts 64-bit packets from the processor through a 2-bit-addressed register interface and injects them into the router (drives pesi/pedi, honours peri).
- Receives packets ejected by the router (consumes peso/pedo, drives pero) and holds them for the processor.
- One single-entry buffer per direction. Injection is gated by the mesh's global even/odd polarity.

Parameters:
- DATA_WIDTH, 64, packet and register width.
- VC_BIT, 63, packet bit holding the virtual-channel (polarity) tag.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  2  register select: 00 rx data, 01 rx status, 10 tx data, 11 tx status.
- d_in  in  DATA_WIDTH  processor write data.
- d_out  out  DATA_WIDTH  processor read data (combinational mux on addr).
- nicEn  in  1  register access enable.
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
- net_so  out  1  send strobe to router (connects to pesi).
- net_do  out  DATA_WIDTH  send data to router (connects to pedi).
- net_ro  in  1  router can accept (from peri).
- net_polarity  in  1  mesh polarity, toggles every cycle.
- net_si  in  1  router ejects a packet (from peso).
- net_di  in  DATA_WIDTH  ejected packet (from pedo).
- net_ri  out  1  NIC can accept an ejected packet (to pero).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: tx_full=0, rx_full=0, tx_buf=0, rx_buf=0, net_so=0, net_do=0, net_ri=1, d_out=0 when nicEn=0.
- Read mux: d_out = nicEn&~nicWrEn ? {addr 00: rx_buf; 01: {63'b0,rx_full}; 10: tx_buf; 11: {63'b0,tx_full}} : 0.
- Processor TX write: nicEn&nicWrEn&addr==10&~tx_full at the edge loads tx_buf<=d_in and sets tx_full. A write while tx_full=1 is silently dropped. Writes to 00, 01 and 11 are ignored.
- Injection (combinational strobe, registered clear):
  - net_so = tx_full & net_ro & (net_polarity == tx_buf[VC_BIT]).
  - net_do = tx_buf whenever tx_full, else 0.
  - At an edge with net_so=1: tx_full<=0. Latency from write to earliest net_so is 1 cycle.
  - A polarity mismatch or net_ro=0 holds the packet indefinitely, with no timeout.
- Same-cycle write and send: tx_full is evaluated pre-edge, so the write is dropped and the send completes. The processor must poll tx status.
- Reception:
  - net_ri = ~rx_full.
  - At an edge with net_si&net_ri: rx_buf<=net_di and rx_full<=1.
  - net_si while rx_full=1 is a router protocol violation; data is ignored and rx_buf is unchanged.
- Processor RX read: nicEn&~nicWrEn&addr==00&rx_full returns rx_buf this cycle and clears rx_full at the edge. net_ri rises the next cycle. Reading 00 while empty returns the stale rx_buf and has no side effect.
- Read and arrival in the same cycle cannot occur, because net_ri=0 while full.
- Reset mid-operation: reset wins over every other event in the same edge. In-flight tx/rx contents are discarded. net_so is forced 0 during reset.
- Per-channel FSM: EMPTY -> FULL on load; FULL -> EMPTY on drain (send or read).

Decomposition:
- Shared package mesh_pkg holds:
  - register address constants (NIC_RX_DATA=2'b00, NIC_RX_STAT=2'b01, NIC_TX_DATA=2'b10, NIC_TX_STAT=2'b11);
  - DATA_WIDTH and VC_BIT;
  - packet field positions reused by the router.
- Sub-module: nic_slot, a single-entry buffer with full flag, load/drain strobes and synchronous reset, instantiated twice (tx and rx).

Test Plan:
- Reset: assert reset 2 cycles with net_si=1 -> net_so=0, net_ri=1, both status reads return 0, rx_buf not loaded.
- TX matched polarity: write 0x8000_0000_0000_00A5 to addr 10, net_ro=1, polarity toggling -> net_so=1 only on the first cycle with polarity=1, net_do=0x8000_0000_0000_00A5, tx status reads 0 next cycle.
- TX hold: write 0x0000_0000_0000_0011, net_ro=0 for 5 cycles -> no net_so, tx status=1. A second write of 0x22 is dropped. Raise net_ro -> net_do=0x11 sent on a polarity=0 cycle.
- RX: drive net_si=1, net_di=0xDEAD_BEEF_0000_0001 for one cycle -> net_ri=0 next cycle, addr 01 reads 1. Read addr 00 -> 0xDEAD_BEEF_0000_0001, then net_ri=1 the cycle after.
- Simultaneous TX drain and RX arrival in the same cycle -> both complete. tx status=0, rx status=1, no interference.
- Reset mid-operation: tx_full=1 with net_ro=0, rx_full=1, assert reset one cycle -> both status 0, net_ri=1, no net_so after release until a new write.
